// File: rtl/vga_frame_renderer_pkg.sv
// Shared constants, state encoding and the 3-bit pixel unpack helper
// for the packed-framebuffer renderer.
package vga_frame_renderer_pkg;

    localparam int PIX_PER_WORD = 10;
    localparam int COLOUR_W     = 3;
    localparam int RAM_AW       = 11;
    localparam int SCREEN_W     = 160;
    localparam int SCREEN_H     = 120;
    localparam int WORD_W       = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLOT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Pixel k lives in bits [3k+2:3k]; pixel 0 is the leftmost on screen.
    function automatic logic [COLOUR_W-1:0] unpack_pixel(input logic [WORD_W-1:0] word,
                                                         input logic [3:0] k);
        logic [WORD_W-1:0] shifted;
        shifted = word >> (6'(k) * 6'd3);
        return shifted[COLOUR_W-1:0];
    endfunction

endpackage

// File: rtl/vga_frame_renderer_if.sv
// RAM-client handshake, RAM read bus and vga_adapter pixel bus of the renderer.
interface vga_frame_renderer_if;
    import vga_frame_renderer_pkg::*;

    logic                enable;
    logic                acknowledge;
    logic [WORD_W-1:0]   dataRead;
    logic [RAM_AW-1:0]   address;
    logic [7:0]          x;
    logic [6:0]          y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;

    modport slave (
        input  enable, dataRead,
        output acknowledge, address, x, y, colour, plot
    );

    modport master (
        output enable, dataRead,
        input  acknowledge, address, x, y, colour, plot
    );

endinterface

// File: rtl/vga_frame_renderer_word_prefetch_buffer.sv
// Tracks in-flight RAM reads and holds one returned word until the renderer consumes it.
// The word/valid outputs bypass straight from dataRead on the cycle the read lands.
module word_prefetch_buffer #(
    parameter int RD_LAT = 1
) (
    input  logic        CLOCK_50,
    input  logic        resetIn,
    input  logic        flush,
    input  logic        issue,
    input  logic        consume,
    input  logic [31:0] dataRead,
    output logic [31:0] word,
    output logic        valid
);

    logic [RD_LAT-1:0] pending;
    logic [31:0]       hold;
    logic              hold_valid;
    logic              arrive;

    assign arrive = pending[RD_LAT-1];
    assign word   = hold_valid ? hold : dataRead;
    assign valid  = hold_valid | arrive;

    always_ff @(posedge CLOCK_50) begin
        if (resetIn || flush) begin
            pending    <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
        end else begin
            pending <= (pending << 1) | RD_LAT'(issue);
            if (arrive && (hold_valid || !consume)) begin
                hold       <= dataRead;
                hold_valid <= 1'b1;
            end else if (consume) begin
                hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vga_frame_renderer.sv
// Walks a packed 3-bit-per-pixel framebuffer and streams one pixel per clock to vga_adapter.
//   state | meaning
//   IDLE  | no grant, outputs quiet, address parked on BASE_ADDR
//   FETCH | first word read in flight, waiting for it to land
//   PLOT  | one pixel per clock, next word prefetched behind the current one
//   DONE  | frame finished, acknowledge held while enable stays high
module vga_frame_renderer
    import vga_frame_renderer_pkg::*;
#(
    parameter logic [RAM_AW-1:0] BASE_ADDR   = 11'd0,
    parameter int                WIDTH_WORDS = 16,
    parameter int                HEIGHT      = 120,
    parameter int                RD_LAT      = 1,
    parameter bit                SKIP_BLACK  = 1'b0
) (
    input  logic                 CLOCK_50,
    input  logic                 resetIn,
    vga_frame_renderer_if.slave  bus
);

    if (RD_LAT < 1 || RD_LAT > 8) begin : g_bad_rd_lat
        $error("vga_frame_renderer: RD_LAT must be within 1..8");
    end

    state_t              state, state_n;
    logic [3:0]          k, k_n, pix_k;
    logic [7:0]          col, col_n, word_x, word_x_n;
    logic [6:0]          row, row_n;
    logic [WORD_W-1:0]   cur_word, cur_word_n, src_word;
    logic [RAM_AW-1:0]   addr_q, addr_n;
    logic [7:0]          x_q, x_n;
    logic [6:0]          y_q, y_n;
    logic [COLOUR_W-1:0] colour_q, colour_n, pix;
    logic                plot_q, plot_n, ack_q, ack_n;
    logic                issue_q, issue_n, consume, flush, present, abort, last_word;
    logic [WORD_W-1:0]   pf_word;
    logic                pf_valid;

    // issue_q is high during the cycle the new address is on the bus
    word_prefetch_buffer #(.RD_LAT(RD_LAT)) u_prefetch (
        .CLOCK_50 (CLOCK_50),
        .resetIn  (resetIn),
        .flush    (flush),
        .issue    (issue_q),
        .consume  (consume),
        .dataRead (bus.dataRead),
        .word     (pf_word),
        .valid    (pf_valid)
    );

    assign last_word = (row == 7'(HEIGHT - 1)) && (col == 8'(WIDTH_WORDS - 1));
    assign abort     = ((state == FETCH) || (state == PLOT)) && !bus.enable;

    always_comb begin
        state_n    = state;
        k_n        = k;
        col_n      = col;
        row_n      = row;
        word_x_n   = word_x;
        cur_word_n = cur_word;
        addr_n     = addr_q;
        x_n        = x_q;
        y_n        = y_q;
        colour_n   = colour_q;
        plot_n     = 1'b0;
        ack_n      = 1'b0;
        issue_n    = 1'b0;
        consume    = 1'b0;
        flush      = 1'b0;
        present    = 1'b0;
        pix_k      = k;
        src_word   = cur_word;
        pix        = '0;

        unique case (state)
            IDLE: begin
                if (bus.enable) begin
                    state_n  = FETCH;
                    addr_n   = BASE_ADDR;
                    issue_n  = 1'b1;
                    k_n      = '0;
                    col_n    = '0;
                    row_n    = '0;
                    word_x_n = '0;
                end
            end
            FETCH: begin
                if (bus.enable && pf_valid) begin
                    present    = 1'b1;
                    pix_k      = 4'd0;
                    src_word   = pf_word;
                    cur_word_n = pf_word;
                    consume    = 1'b1;
                    state_n    = PLOT;
                end
            end
            PLOT: begin
                if (bus.enable) present = 1'b1;
            end
            DONE: begin
                if (bus.enable) begin
                    ack_n = 1'b1;
                end else begin
                    state_n = IDLE;
                    addr_n  = BASE_ADDR;
                end
            end
        endcase

        if (present) begin
            pix      = unpack_pixel(src_word, pix_k);
            x_n      = word_x + {4'd0, pix_k};
            y_n      = row;
            colour_n = pix;
            plot_n   = !(SKIP_BLACK && (pix == '0));
            if ((pix_k == 4'd0) && !last_word) begin
                issue_n = 1'b1;
                addr_n  = addr_q + 11'd1;
            end
            if (pix_k == 4'(PIX_PER_WORD - 1)) begin
                k_n = '0;
                // The last pixel's edge moves to DONE; plot drops and ack rises on the next edge.
                if (last_word) begin
                    state_n = DONE;
                end else begin
                    consume    = 1'b1;
                    cur_word_n = pf_word;
                    if (col == 8'(WIDTH_WORDS - 1)) begin
                        col_n    = '0;
                        word_x_n = '0;
                        row_n    = row + 7'd1;
                    end else begin
                        col_n    = col + 8'd1;
                        word_x_n = word_x + 8'(PIX_PER_WORD);
                    end
                end
            end else begin
                k_n = pix_k + 4'd1;
            end
        end

        if (abort) begin
            state_n  = IDLE;
            flush    = 1'b1;
            addr_n   = BASE_ADDR;
            k_n      = '0;
            col_n    = '0;
            row_n    = '0;
            word_x_n = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (resetIn) begin
            state    <= IDLE;
            k        <= '0;
            col      <= '0;
            row      <= '0;
            word_x   <= '0;
            cur_word <= '0;
            addr_q   <= BASE_ADDR;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            ack_q    <= 1'b0;
            issue_q  <= 1'b0;
        end else begin
            state    <= state_n;
            k        <= k_n;
            col      <= col_n;
            row      <= row_n;
            word_x   <= word_x_n;
            cur_word <= cur_word_n;
            addr_q   <= addr_n;
            x_q      <= x_n;
            y_q      <= y_n;
            colour_q <= colour_n;
            plot_q   <= plot_n;
            ack_q    <= ack_n;
            issue_q  <= issue_n;
        end
    end

    assign bus.address     = addr_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.colour      = colour_q;
    assign bus.plot        = plot_q;
    assign bus.acknowledge = ack_q;

endmodule

// File: doc/vga_frame_renderer.md
Name: vga_frame_renderer

Overview:
- Downstream of the shared-RAM arbiter. When the arbiter grants it the RAM, the block walks a packed framebuffer region, unpacks 3-bit pixels and drives x/y/colour/plot into vga_adapter at 160x120.
- Uses an enable/acknowledge handshake identical to the other RAM clients.
- Prefetches the next RAM word while plotting the current one, giving one pixel per clock after the initial read latency.

Parameters:
- BASE_ADDR, 11'd0: RAM word address of pixel (0,0).
- WIDTH_WORDS, 16: words per row; 10 pixels per word gives 160 px.
- HEIGHT, 120: rows per frame.
- RD_LAT, 1: RAM read latency in cycles, address to dataRead valid. Legal range 1..8.
- SKIP_BLACK, 0: if 1, colour 3'b000 pixels are not plotted (plot held low); x/y still advance.

Ports:
- CLOCK_50, in, 1: clock.
- resetIn, in, 1: synchronous, active-high reset.
- enable, in, 1: grant from arbiter, level-held.
- acknowledge, out, 1: frame complete.
- dataRead, in, 32: RAM read data.
- address, out, 11: RAM word address. Read-only client; no write port.
- x, out, 8: pixel column 0..159.
- y, out, 7: pixel row 0..119.
- colour, out, 3: pixel colour.
- plot, out, 1: vga_adapter write strobe.

Behaviour:
- Reset values: state IDLE; acknowledge=0, plot=0, x=0, y=0, colour=0, address=BASE_ADDR; word index 0; prefetch buffer invalid.
- Word format: pixel k (0..9) = dataRead[3k+2:3k]; bits 31:30 are ignored. Pixel 0 is leftmost.
- Word index w = row*WIDTH_WORDS + col.
- address = BASE_ADDR + w, mod 2048 (wraps silently).
- x = col*10 + k; y = row.

State machine:
- IDLE: outputs quiet. enable=1 -> FETCH, with address=BASE_ADDR on the next cycle.
- FETCH:
  - Hold address for RD_LAT cycles.
  - Capture dataRead into the current-word register.
  - Drive address to word 1; go to PLOT.
  - First plot pulse occurs exactly RD_LAT+1 cycles after FETCH is entered.
- PLOT:
  - Each cycle: present pixel k; plot=1 (unless the SKIP_BLACK rule applies); k increments.
  - The word w+1 read is issued at k=0 and captured into the prefetch buffer RD_LAT cycles later.
  - At k=9: load the current-word register from the prefetch buffer, k=0, advance col/row, issue the next prefetch.
  - Plot cycles are contiguous with no bubbles across words or rows: WIDTH_WORDS*HEIGHT*10 cycles total (19200 at defaults).
  - The prefetch for the word after the last is suppressed; address holds the last word.
- DONE:
  - Entered the cycle after the last plot; plot=0.
  - acknowledge=1 while enable=1.
  - enable=0 -> IDLE with acknowledge=0 on the same edge.
  - Re-entry requires enable to be low for at least one cycle.

Boundary rules:
- enable drops during FETCH/PLOT: abort on the next edge to IDLE. plot=0 and acknowledge=0 that cycle; counters reset; the next grant restarts at (0,0).
- resetIn has priority over enable in every state; reset mid-frame gives reset values on the next edge.
- Row wrap: col=WIDTH_WORDS-1, k=9 -> col=0, row+1. Last pixel: row=HEIGHT-1, col=WIDTH_WORDS-1, k=9.
- RD_LAT outside 1..8: elaboration error (generate-time check).
- x/y/colour are registered and change only with plot or at reset. With plot=0, x/y/colour are don't-care to vga_adapter but held stable.

Decomposition:
- Shared package:
  - PIX_PER_WORD=10, COLOUR_W=3, RAM_AW=11, SCREEN_W=160, SCREEN_H=120.
  - State encoding constants IDLE/FETCH/PLOT/DONE.
- Sub-module word_prefetch_buffer: an RD_LAT-deep valid shift register plus one 32-bit holding register. Inputs: issue pulse, dataRead, consume. Outputs: buffered word and valid flag.

Test Plan:
- Default params, RAM filled with w -> {2'b00, 10 copies of (w mod 8)}, enable held: 19200 contiguous plot cycles, x wraps 159->0 with y+1, first plot at RD_LAT+1 after FETCH entry, acknowledge high on cycle 19200+RD_LAT+2 after the enable edge.
- WIDTH_WORDS=2, HEIGHT=2, RD_LAT=3, word0=32'h3FFF_FFFF: pixels (0..9,0) have colour 7, no plot gap between x=9 and x=10, address sequence 0,1,2,3.
- SKIP_BLACK=1, word with alternating colours 0/5: plot low on even k, high on odd k, x still advancing by 1 each cycle.
- enable dropped at plot #37: next cycle plot=0, state IDLE; re-grant restarts with first plot at x=0, y=0.
- resetIn pulsed for 1 cycle mid-frame with enable high: all outputs at reset values next edge, then a fresh frame from (0,0).
- enable held high after DONE: acknowledge stays 1 and there are no new plots; drop enable -> acknowledge=0 on the same edge.
